latency_monitor: RTL and testbench
==================================

// Module: latency_monitor
// PURPOSE
//  Parametrised tick-to-trade latency monitor: generalises single-shot timestamp_latch + first-beat pulses.
//  Taps the RX payload stream (header_skip -> parser) and TX stream (hdr inserter -> MAC) in fabric_clk domain.
//  Queues RX start-of-frame timestamps (multiple in flight) and pairs each TX SOF with the oldest queued RX timestamp.
//  Keeps last/min/max/sum/count latency statistics for ILA/register readout. Passive: never drives tready.
// PARAMETERS
//  TS_WIDTH   64  width of free-running timestamp input
//  LAT_WIDTH  32  latency result width; larger differences saturate to all-ones
//  DEPTH      8   outstanding RX SOF timestamps (power of 2, >=2)
//  CNT_WIDTH  32  width of sample/drop/orphan counters (saturating)
//  SUM_WIDTH  48  latency accumulator width (saturating)
//  NUM_BINS   16  histogram bins (power of 2; LAT_HIST_EN only)
//  BIN_SHIFT  3   histogram bin = lat >> BIN_SHIFT, clamped to NUM_BINS-1
// PORTS
//  clk            in   1          fabric clock, single clock domain
//  rst            in   1          asynchronous active-high reset
//  ts             in   TS_WIDTH   free-running timestamp (timestamp_counter)
//  rx_tvalid/rx_tready/rx_tlast in 1 each  RX payload tap
//  tx_tvalid/tx_tready/tx_tlast in 1 each  TX stream tap
//  stats_clear    in   1          sync pulse: clear statistics and counters (FIFO untouched)
//  lat_valid      out  1          one-cycle pulse: new latency sample
//  lat_last       out  LAT_WIDTH  most recent latency
//  lat_min/lat_max out LAT_WIDTH  running min / max
//  lat_sum        out  SUM_WIDTH  running sum
//  lat_count      out  CNT_WIDTH  samples accumulated
//  rx_drop_cnt    out  CNT_WIDTH  RX SOFs dropped, FIFO full
//  tx_orphan_cnt  out  CNT_WIDTH  TX SOFs with empty FIFO
//  fifo_level     out  $clog2(DEPTH)+1  queued RX timestamps
//  hist_rd_idx    in   $clog2(NUM_BINS) histogram read index
//  hist_rd_data   out  CNT_WIDTH  bin count, registered (1-cycle read latency)
// BEHAVIOUR
//  Reset (async): all outputs 0 except lat_min = all-ones; FIFO empty; in_frame flags 0.
//  SOF per tap: beat = tvalid&tready; sof = beat & !in_frame; in_frame <= 1 on sof, <= 0 on beat&tlast (tlast wins: single-beat frame leaves in_frame=0).
//  Capture: ts sampled in the SOF handshake cycle N.
//  RX SOF, FIFO not full: push ts. Full: drop, rx_drop_cnt++ (saturating).
//  TX SOF, FIFO not empty: pop head. Empty: tx_orphan_cnt++; no sample. Same-cycle RX SOF is pushed, never paired.
//  Same-cycle push+pop: both succeed, incl. when full (pop frees slot) or when holding 1 entry.
//  Pipeline: N+1 diff = (tx_ts - rx_ts) mod 2^TS_WIDTH; N+2 saturate to LAT_WIDTH, lat_valid=1, lat_last and stats updated.
//  Back-to-back TX SOFs each cycle sustained; one sample per cycle max.
//  Stats: min/max compare vs saturated value; lat_sum, lat_count saturate at all-ones, never wrap.
//  stats_clear: next cycle min=all-ones, max/sum/count/drop/orphan/hist=0. Clear wins over a same-cycle stats update.
//   That sample still appears on lat_valid/lat_last.
//  ts wrap between RX and TX handled by modular subtract.
// CONFIGURATION
//  LATENCY_MON_HIST_EN defined: NUM_BINS x CNT_WIDTH histogram, saturating per-bin increment on each counted sample.
//   Cleared by stats_clear; read via hist_rd_idx -> hist_rd_data next cycle.
//  Undefined: no histogram storage; hist_rd_data tied 0; ports retained for ILA/top compatibility.
// STRUCTURE
//  Shared header latency_mon_defs.vh: default widths, LAT_SAT / MIN_INIT constants, clog2 helper function.
//  Sub-module ts_sync_fifo: DEPTH x TS_WIDTH sync FIFO, async rst; push/pop/full/empty/level; simultaneous push+pop when full allowed.
//  Top body: two SOF detectors, 2-stage latency pipeline, stats regs, optional histogram.
// TESTING
//  1 RX SOF at ts=100, TX SOF at ts=350 -> lat_valid 2 cycles after TX SOF, lat_last=min=max=sum=250, count=1.
//  RX SOFs at ts 10,20,30; TX SOFs at 110,125,200 -> lats 100,105,170; min=100, max=170, sum=375, count=3.
//  9 RX SOFs, no TX, DEPTH=8 -> fifo_level=8, rx_drop_cnt=1; TX SOF with empty FIFO -> tx_orphan_cnt=1, no lat_valid.
//  rx_ts=2^64-5, tx_ts=15 -> lat=20. Diff 2^33 -> lat_last=0xFFFFFFFF.
//  stats_clear same cycle as lat_valid -> count=0, min=all-ones. Multi-beat frames with tvalid gaps and tready stalls -> one SOF per frame.
//  Async rst mid-frame with 3 queued -> all outputs reset immediately; next TX SOF is orphan.
//  With LATENCY_MON_HIST_EN: lats 5,9,200 (BIN_SHIFT=3) -> bin0=1, bin1=1, bin15=1.

Source files
------------

// File: rtl/latency_monitor_pkg.sv
// Shared defaults and helpers for the tick-to-trade latency monitor.
// Optional histogram build switch: LATENCY_MON_HIST_EN.
package latency_monitor_pkg;

  localparam int unsigned LM_TS_WIDTH  = 64;
  localparam int unsigned LM_LAT_WIDTH = 32;
  localparam int unsigned LM_DEPTH     = 8;
  localparam int unsigned LM_CNT_WIDTH = 32;
  localparam int unsigned LM_SUM_WIDTH = 48;
  localparam int unsigned LM_NUM_BINS  = 16;
  localparam int unsigned LM_BIN_SHIFT = 3;

  // Ceiling log2 for sizing pointers and index ports at elaboration time.
  function automatic int unsigned lm_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/ts_sync_fifo.sv
// Single-clock FIFO of RX start-of-frame timestamps.
// Push and pop may occur in the same cycle, including when full.
module ts_sync_fifo
  import latency_monitor_pkg::*;
#(
  parameter int unsigned WIDTH = LM_TS_WIDTH,
  parameter int unsigned DEPTH = LM_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_push,
  input  logic                        i_pop,
  input  logic [WIDTH-1:0]            i_din,
  output logic [WIDTH-1:0]            o_dout,
  output logic                        o_full,
  output logic                        o_empty,
  output logic [lm_clog2(DEPTH):0]    o_level
);

  localparam int unsigned AW = lm_clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Timestamp storage write port.
  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == (AW+1)'(DEPTH));
  assign o_empty = (r_wr_ptr == r_rd_ptr);

endmodule

// File: rtl/latency_monitor.sv
// Passive tick-to-trade latency monitor: pairs each TX start-of-frame with the
// oldest queued RX start-of-frame timestamp and keeps running statistics.
// Define LATENCY_MON_HIST_EN to build the latency histogram.
module latency_monitor
  import latency_monitor_pkg::*;
#(
  parameter int unsigned TS_WIDTH  = LM_TS_WIDTH,
  parameter int unsigned LAT_WIDTH = LM_LAT_WIDTH,
  parameter int unsigned DEPTH     = LM_DEPTH,
  parameter int unsigned CNT_WIDTH = LM_CNT_WIDTH,
  parameter int unsigned SUM_WIDTH = LM_SUM_WIDTH,
  parameter int unsigned NUM_BINS  = LM_NUM_BINS,
  parameter int unsigned BIN_SHIFT = LM_BIN_SHIFT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [TS_WIDTH-1:0]           ts,
  input  logic                          rx_tvalid,
  input  logic                          rx_tready,
  input  logic                          rx_tlast,
  input  logic                          tx_tvalid,
  input  logic                          tx_tready,
  input  logic                          tx_tlast,
  input  logic                          stats_clear,
  output logic                          lat_valid,
  output logic [LAT_WIDTH-1:0]          lat_last,
  output logic [LAT_WIDTH-1:0]          lat_min,
  output logic [LAT_WIDTH-1:0]          lat_max,
  output logic [SUM_WIDTH-1:0]          lat_sum,
  output logic [CNT_WIDTH-1:0]          lat_count,
  output logic [CNT_WIDTH-1:0]          rx_drop_cnt,
  output logic [CNT_WIDTH-1:0]          tx_orphan_cnt,
  output logic [lm_clog2(DEPTH):0]      fifo_level,
  input  logic [lm_clog2(NUM_BINS)-1:0] hist_rd_idx,
  output logic [CNT_WIDTH-1:0]          hist_rd_data
);

  logic                  w_rx_beat, w_rx_sof, w_tx_beat, w_tx_sof;
  logic                  r_rx_in_frame, r_tx_in_frame;
  logic                  w_push, w_pop, w_rx_drop, w_tx_orphan;
  logic                  w_fifo_full, w_fifo_empty;
  logic [TS_WIDTH-1:0]   w_fifo_head;
  logic                  r_s1_valid;
  logic [TS_WIDTH-1:0]   r_s1_diff;
  logic [LAT_WIDTH-1:0]  w_lat_sat;
  logic [SUM_WIDTH:0]    w_sum_ext;
  logic                  r_lat_valid;
  logic [LAT_WIDTH-1:0]  r_lat_last, r_lat_min, r_lat_max;
  logic [SUM_WIDTH-1:0]  r_lat_sum;
  logic [CNT_WIDTH-1:0]  r_lat_count, r_rx_drop_cnt, r_tx_orphan_cnt;

  assign w_rx_beat = rx_tvalid & rx_tready;
  assign w_tx_beat = tx_tvalid & tx_tready;
  assign w_rx_sof  = w_rx_beat & ~r_rx_in_frame;
  assign w_tx_sof  = w_tx_beat & ~r_tx_in_frame;

  // Track frame boundaries; a beat with tlast always ends the frame, even a single-beat one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_in_frame <= 1'b0;
      r_tx_in_frame <= 1'b0;
    end else begin
      if (w_rx_beat) r_rx_in_frame <= ~rx_tlast;
      if (w_tx_beat) r_tx_in_frame <= ~tx_tlast;
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO can still accept the push.
  // An RX SOF arriving alongside a TX SOF on an empty FIFO is queued, not paired.
  assign w_pop       = w_tx_sof & ~w_fifo_empty;
  assign w_push      = w_rx_sof & (~w_fifo_full | w_pop);
  assign w_rx_drop   = w_rx_sof & w_fifo_full & ~w_pop;
  assign w_tx_orphan = w_tx_sof & w_fifo_empty;

  ts_sync_fifo #(
    .WIDTH (TS_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (ts),
    .o_dout  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  // Stage 1: modular difference, so a timestamp wrap between RX and TX is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_diff  <= '0;
    end else begin
      r_s1_valid <= w_pop;
      if (w_pop) r_s1_diff <= ts - w_fifo_head;
    end
  end

  // Saturate the difference to the latency width and form the saturating sum.
  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_lat_sat = '1;
    if (r_s1_diff <= TS_WIDTH'({LAT_WIDTH{1'b1}})) w_lat_sat = r_s1_diff[LAT_WIDTH-1:0];
    w_sum_ext = {1'b0, r_lat_sum} + (SUM_WIDTH+1)'(w_lat_sat);
  end

  // Stage 2: publish the sample; it appears even when statistics are being cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_valid <= 1'b0;
      r_lat_last  <= '0;
    end else begin
      r_lat_valid <= r_s1_valid;
      if (r_s1_valid) r_lat_last <= w_lat_sat;
    end
  end

  // Running statistics and event counters; a clear takes priority over any update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lat_min       <= '1;
      r_lat_max       <= '0;
      r_lat_sum       <= '0;
      r_lat_count     <= '0;
      r_rx_drop_cnt   <= '0;
      r_tx_orphan_cnt <= '0;
    end else if (stats_clear) begin
      r_lat_min       <= '1;
      r_lat_max       <= '0;
      r_lat_sum       <= '0;
      r_lat_count     <= '0;
      r_rx_drop_cnt   <= '0;
      r_tx_orphan_cnt <= '0;
    end else begin
      if (r_s1_valid) begin
        if (w_lat_sat < r_lat_min) r_lat_min <= w_lat_sat;
        if (w_lat_sat > r_lat_max) r_lat_max <= w_lat_sat;
        r_lat_sum <= w_sum_ext[SUM_WIDTH] ? '1 : w_sum_ext[SUM_WIDTH-1:0];
        if (r_lat_count != '1) r_lat_count <= r_lat_count + 1'b1;
      end
      if (w_rx_drop && r_rx_drop_cnt != '1)     r_rx_drop_cnt   <= r_rx_drop_cnt + 1'b1;
      if (w_tx_orphan && r_tx_orphan_cnt != '1) r_tx_orphan_cnt <= r_tx_orphan_cnt + 1'b1;
    end
  end

  assign lat_valid     = r_lat_valid;
  assign lat_last      = r_lat_last;
  assign lat_min       = r_lat_min;
  assign lat_max       = r_lat_max;
  assign lat_sum       = r_lat_sum;
  assign lat_count     = r_lat_count;
  assign rx_drop_cnt   = r_rx_drop_cnt;
  assign tx_orphan_cnt = r_tx_orphan_cnt;

`ifdef LATENCY_MON_HIST_EN
  localparam int unsigned BW = lm_clog2(NUM_BINS);

  logic [CNT_WIDTH-1:0] r_hist [NUM_BINS];
  logic [BW-1:0]        w_bin;
  logic [CNT_WIDTH-1:0] r_hist_rd_data;

  // Bin index from the saturated latency, clamped into the last bin.
  always_comb begin
    w_bin = BW'(NUM_BINS - 1);
    if ((w_lat_sat >> BIN_SHIFT) < LAT_WIDTH'(NUM_BINS)) w_bin = BW'(w_lat_sat >> BIN_SHIFT);
  end

  // Histogram bins are small and must read zero after reset, so they are reset explicitly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BINS); i++) r_hist[i] <= '0;
    end else if (stats_clear) begin
      for (int i = 0; i < int'(NUM_BINS); i++) r_hist[i] <= '0;
    end else if (r_s1_valid && r_hist[w_bin] != '1) begin
      r_hist[w_bin] <= r_hist[w_bin] + 1'b1;
    end
  end

  // Registered read port: data for hist_rd_idx appears on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_hist_rd_data <= '0;
    else     r_hist_rd_data <= r_hist[hist_rd_idx];
  end

  assign hist_rd_data = r_hist_rd_data;
`else
  // Histogram omitted: the read port stays for interface compatibility and reads zero.
  logic w_unused_hist;
  assign w_unused_hist = ^{hist_rd_idx, BIN_SHIFT[0]};
  assign hist_rd_data  = '0;
`endif

endmodule

// File: tb/tb_latency_monitor.sv
// Directed self-checking bench for latency_monitor (default parameters).
// Build with LATENCY_MON_HIST_EN defined to also exercise the histogram.
module tb_latency_monitor;

  logic        clk;
  logic        rst;
  logic [63:0] ts;
  logic        rx_tvalid, rx_tready, rx_tlast;
  logic        tx_tvalid, tx_tready, tx_tlast;
  logic        stats_clear;
  logic        lat_valid;
  logic [31:0] lat_last, lat_min, lat_max;
  logic [47:0] lat_sum;
  logic [31:0] lat_count, rx_drop_cnt, tx_orphan_cnt;
  logic [3:0]  fifo_level;
  logic [3:0]  hist_rd_idx;
  logic [31:0] hist_rd_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] got_q[$];

  latency_monitor dut (
    .clk           (clk),
    .rst           (rst),
    .ts            (ts),
    .rx_tvalid     (rx_tvalid),
    .rx_tready     (rx_tready),
    .rx_tlast      (rx_tlast),
    .tx_tvalid     (tx_tvalid),
    .tx_tready     (tx_tready),
    .tx_tlast      (tx_tlast),
    .stats_clear   (stats_clear),
    .lat_valid     (lat_valid),
    .lat_last      (lat_last),
    .lat_min       (lat_min),
    .lat_max       (lat_max),
    .lat_sum       (lat_sum),
    .lat_count     (lat_count),
    .rx_drop_cnt   (rx_drop_cnt),
    .tx_orphan_cnt (tx_orphan_cnt),
    .fifo_level    (fifo_level),
    .hist_rd_idx   (hist_rd_idx),
    .hist_rd_data  (hist_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every published sample, sampled mid-cycle.
  always @(negedge clk) if (lat_valid === 1'b1) got_q.push_back(lat_last);

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rx_sof(input logic [63:0] t);
    ts = t; rx_tvalid = 1'b1; rx_tlast = 1'b1;
    cycle();
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
  endtask

  task automatic tx_sof(input logic [63:0] t);
    ts = t; tx_tvalid = 1'b1; tx_tlast = 1'b1;
    cycle();
    tx_tvalid = 1'b0; tx_tlast = 1'b0;
  endtask

  task automatic both_sof(input logic [63:0] t);
    ts = t; rx_tvalid = 1'b1; rx_tlast = 1'b1; tx_tvalid = 1'b1; tx_tlast = 1'b1;
    cycle();
    rx_tvalid = 1'b0; rx_tlast = 1'b0; tx_tvalid = 1'b0; tx_tlast = 1'b0;
  endtask

  task automatic clear_stats();
    stats_clear = 1'b1;
    cycle();
    stats_clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
  endtask

  typedef struct {
    logic [63:0] rx_ts;
    logic [63:0] tx_ts;
    logic [31:0] exp_lat;
  } lat_vec_t;

  lat_vec_t vecs[6];
  int       qsz;

  initial begin
    vecs[0] = '{64'd100,                   64'd350,           32'd250};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFB,   64'd15,            32'd20};
    vecs[2] = '{64'd0,                     64'h2_0000_0000,   32'hFFFF_FFFF};
    vecs[3] = '{64'd7,                     64'd7,             32'd0};
    vecs[4] = '{64'd1000,                  64'h1_0000_03E7,   32'hFFFF_FFFF};
    vecs[5] = '{64'd1000,                  64'h1_0000_03E8,   32'hFFFF_FFFF};

    rst = 1'b1; ts = '0; stats_clear = 1'b0; hist_rd_idx = '0;
    rx_tvalid = 1'b0; rx_tready = 1'b1; rx_tlast = 1'b0;
    tx_tvalid = 1'b0; tx_tready = 1'b1; tx_tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cycle();

    // Reset state
    check("rst_lat_valid", 64'(lat_valid), 64'd0);
    check("rst_lat_last",  64'(lat_last),  64'd0);
    check("rst_lat_min",   64'(lat_min),   64'hFFFF_FFFF);
    check("rst_lat_max",   64'(lat_max),   64'd0);
    check("rst_lat_sum",   64'(lat_sum),   64'd0);
    check("rst_lat_count", 64'(lat_count), 64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);

    // Single-pair vectors: latency, wrap and saturation boundaries
    foreach (vecs[i]) begin
      clear_stats();
      rx_sof(vecs[i].rx_ts);
      tx_sof(vecs[i].tx_ts);
      check($sformatf("v%0d_valid_early", i), 64'(lat_valid), 64'd0);
      cycle();
      check($sformatf("v%0d_valid", i), 64'(lat_valid), 64'd1);
      check($sformatf("v%0d_last",  i), 64'(lat_last),  64'(vecs[i].exp_lat));
      check($sformatf("v%0d_min",   i), 64'(lat_min),   64'(vecs[i].exp_lat));
      check($sformatf("v%0d_max",   i), 64'(lat_max),   64'(vecs[i].exp_lat));
      check($sformatf("v%0d_sum",   i), 64'(lat_sum),   64'(vecs[i].exp_lat));
      check($sformatf("v%0d_count", i), 64'(lat_count), 64'd1);
    end
    cycle();
    check("valid_is_pulse", 64'(lat_valid), 64'd0);

    // Three in flight, back-to-back TX SOFs
    clear_stats();
    got_q.delete();
    rx_sof(64'd10); rx_sof(64'd20); rx_sof(64'd30);
    check("multi_level3", 64'(fifo_level), 64'd3);
    tx_sof(64'd110); tx_sof(64'd125); tx_sof(64'd200);
    cycle(); cycle();
    check("multi_nsamples", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("multi_lat0", 64'(got_q[0]), 64'd100);
      check("multi_lat1", 64'(got_q[1]), 64'd105);
      check("multi_lat2", 64'(got_q[2]), 64'd170);
    end
    check("multi_min",   64'(lat_min),   64'd100);
    check("multi_max",   64'(lat_max),   64'd170);
    check("multi_sum",   64'(lat_sum),   64'd375);
    check("multi_count", 64'(lat_count), 64'd3);

    // Multi-beat frames with tvalid gaps and tready stalls: one SOF per frame
    got_q.delete();
    ts = 64'd1000; rx_tvalid = 1'b1; rx_tlast = 1'b0; cycle();
    ts = 64'd1001; rx_tready = 1'b0; cycle();
    rx_tready = 1'b1; rx_tvalid = 1'b0; cycle();
    rx_tvalid = 1'b1; cycle();
    rx_tlast = 1'b1; cycle();
    rx_tvalid = 1'b0; rx_tlast = 1'b0;
    check("frame_rx_level", 64'(fifo_level), 64'd1);
    ts = 64'd1400; tx_tvalid = 1'b1; tx_tlast = 1'b0; cycle();
    ts = 64'd1401; tx_tready = 1'b0; cycle();
    tx_tready = 1'b1; tx_tvalid = 1'b0; cycle();
    tx_tvalid = 1'b1; tx_tlast = 1'b1; cycle();
    tx_tvalid = 1'b0; tx_tlast = 1'b0;
    cycle(); cycle();
    check("frame_nsamples", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("frame_lat", 64'(got_q[0]), 64'd400);
    check("frame_tx_level", 64'(fifo_level), 64'd0);

    // Fill past depth, then push+pop while full
    clear_stats();
    got_q.delete();
    for (int i = 0; i < 9; i++) rx_sof(64'(10 * i));
    check("full_level", 64'(fifo_level), 64'd8);
    check("full_drop",  64'(rx_drop_cnt), 64'd1);
    both_sof(64'd1000);
    cycle(); cycle();
    check("fullpp_level",  64'(fifo_level), 64'd8);
    check("fullpp_drop",   64'(rx_drop_cnt), 64'd1);
    check("fullpp_orphan", 64'(tx_orphan_cnt), 64'd0);
    check("fullpp_n",      64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("fullpp_lat", 64'(got_q[0]), 64'd1000);

    // stats_clear in the same cycle the sample lands: clear wins, sample still shown
    tx_sof(64'd3000);
    stats_clear = 1'b1;
    cycle();
    stats_clear = 1'b0;
    check("clr_valid", 64'(lat_valid), 64'd1);
    check("clr_last",  64'(lat_last),  64'd2990);
    check("clr_count", 64'(lat_count), 64'd0);
    check("clr_min",   64'(lat_min),   64'hFFFF_FFFF);
    check("clr_max",   64'(lat_max),   64'd0);
    check("clr_sum",   64'(lat_sum),   64'd0);
    check("clr_level", 64'(fifo_level), 64'd7);

    // Async reset mid-frame with entries queued
    rx_sof(64'd4000);
    ts = 64'd4010; rx_tvalid = 1'b1; rx_tlast = 1'b0; cycle();
    rx_tvalid = 1'b0;
    check("pre_rst_drop", 64'(rx_drop_cnt), 64'd1);
    #3 rst = 1'b1;
    #1;
    check("arst_level",   64'(fifo_level), 64'd0);
    check("arst_drop",    64'(rx_drop_cnt), 64'd0);
    check("arst_last",    64'(lat_last),   64'd0);
    check("arst_min",     64'(lat_min),    64'hFFFF_FFFF);
    #1 rst = 1'b0;
    cycle();
    qsz = got_q.size();
    tx_sof(64'd5000);
    cycle(); cycle();
    check("orphan_cnt",  64'(tx_orphan_cnt), 64'd1);
    check("orphan_nlat", 64'(got_q.size()), 64'(qsz));
    both_sof(64'd6000);
    cycle(); cycle();
    check("empty_pp_orphan", 64'(tx_orphan_cnt), 64'd2);
    check("empty_pp_level",  64'(fifo_level), 64'd1);
    check("empty_pp_nlat",   64'(got_q.size()), 64'(qsz));

`ifdef LATENCY_MON_HIST_EN
    // Histogram: lats 5, 9, 200 land in bins 0, 1 and clamped 15
    do_reset();
    rx_sof(64'd0); rx_sof(64'd0); rx_sof(64'd0);
    tx_sof(64'd5); tx_sof(64'd9); tx_sof(64'd200);
    cycle(); cycle();
    hist_rd_idx = 4'd0;  cycle(); check("hist_bin0",  64'(hist_rd_data), 64'd1);
    hist_rd_idx = 4'd1;  cycle(); check("hist_bin1",  64'(hist_rd_data), 64'd1);
    hist_rd_idx = 4'd15; cycle(); check("hist_bin15", 64'(hist_rd_data), 64'd1);
    hist_rd_idx = 4'd2;  cycle(); check("hist_bin2",  64'(hist_rd_data), 64'd0);
    clear_stats();
    hist_rd_idx = 4'd15; cycle(); check("hist_clr15", 64'(hist_rd_data), 64'd0);
`else
    hist_rd_idx = 4'd3; cycle();
    check("hist_tied0", 64'(hist_rd_data), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
